// File: rtl/myip_sched_pkg.sv
// myip_sched_pkg: state encodings, default parameters and index-width helper for myip_txn_scheduler
package myip_sched_pkg;
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] INIT      = 3'd1;
    localparam logic [2:0] WAIT_DONE = 3'd2;
    localparam logic [2:0] REPORT    = 3'd3;
    localparam logic [2:0] GAP       = 3'd4;
    localparam int DEF_NUM_REQ           = 2;
    localparam int DEF_INIT_PULSE_CYCLES = 1;
    localparam int DEF_GAP_CYCLES        = 2;
    localparam int DEF_CNT_WIDTH         = 16;
    localparam int DEF_TIMEOUT_CYCLES    = 4096;
    function automatic int req_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/myip_rr_picker.sv
// myip_rr_picker: combinational round-robin selector starting one past last
module myip_rr_picker import myip_sched_pkg::*; #(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int IW = req_idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx
);
    logic [NUM_REQ-1:0] rot;
    int off;
    // rotate so bit 0 is the requester right after last, then take the lowest set bit
    always_comb begin
        rot = NUM_REQ'({req, req} >> (int'(last) + 1));
        off = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) off = rot[k] ? k : off;
        idx = IW'((int'(last) + 1 + off) % NUM_REQ);
        grant = (|req) ? (NUM_REQ'(1) << idx) : '0;
    end
endmodule

// File: rtl/myip_txn_scheduler.sv
// myip_txn_scheduler: round-robin sharing of the myip M_AXI burst engine across requesters
// MYIP_SCHED_TIMEOUT_EN adds the WAIT_DONE timeout and the sticky TIMEOUT output
module myip_txn_scheduler import myip_sched_pkg::*; #(
    parameter int NUM_REQ           = DEF_NUM_REQ,
    parameter int INIT_PULSE_CYCLES = DEF_INIT_PULSE_CYCLES,
    parameter int GAP_CYCLES        = DEF_GAP_CYCLES,
    parameter int CNT_WIDTH         = DEF_CNT_WIDTH
`ifdef MYIP_SCHED_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic [NUM_REQ-1:0]   REQ_VALID,
    output logic [NUM_REQ-1:0]   REQ_GRANT,
    output logic [NUM_REQ-1:0]   REQ_DONE,
    output logic [NUM_REQ-1:0]   REQ_ERROR,
    output logic                 M_AXI_INIT_AXI_TXN,
    input  logic                 M_AXI_TXN_DONE,
    input  logic                 M_AXI_ERROR,
    output logic                 BUSY,
    output logic [CNT_WIDTH-1:0] RUN_COUNT,
    output logic [CNT_WIDTH-1:0] ERR_COUNT
`ifdef MYIP_SCHED_TIMEOUT_EN
    , output logic               TIMEOUT
`endif
);
    localparam int IW = req_idx_w(NUM_REQ);
    localparam int PW = $clog2(INIT_PULSE_CYCLES + 1);
    logic [2:0]         state;
    logic [IW-1:0]      last_grant, pick_idx;
    logic [NUM_REQ-1:0] pick_grant;
    logic [PW-1:0]      init_cnt;
    logic [7:0]         gap_cnt;
    logic               armed, err_cap, done_edge;
`ifdef MYIP_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]      tcnt;
`endif

    myip_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req   (REQ_VALID),
        .last  (last_grant),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // first INIT cycle carries the grant pulse, INIT rises on the next one
    assign BUSY               = state != IDLE;
    assign M_AXI_INIT_AXI_TXN = (state == INIT) && (init_cnt != '0);
    assign REQ_GRANT          = (state == INIT && init_cnt == '0) ? NUM_REQ'(1) << last_grant : '0;
    assign REQ_DONE           = (state == REPORT) ? NUM_REQ'(1) << last_grant : '0;
    assign REQ_ERROR          = REQ_DONE & {NUM_REQ{err_cap}};
    assign done_edge          = armed && M_AXI_TXN_DONE;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state      <= IDLE;
            last_grant <= IW'(NUM_REQ - 1);
            init_cnt   <= '0;
            gap_cnt    <= '0;
            armed      <= 1'b0;
            err_cap    <= 1'b0;
            RUN_COUNT  <= '0;
            ERR_COUNT  <= '0;
`ifdef MYIP_SCHED_TIMEOUT_EN
            tcnt       <= '0;
            TIMEOUT    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (|pick_grant) begin
                    last_grant <= pick_idx;
                    init_cnt   <= '0;
                    armed      <= 1'b0;
`ifdef MYIP_SCHED_TIMEOUT_EN
                    tcnt       <= '0;
`endif
                    state      <= INIT;
                end
                INIT: begin
                    if (!M_AXI_TXN_DONE) armed <= 1'b1;
                    if (init_cnt != PW'(INIT_PULSE_CYCLES)) init_cnt <= init_cnt + 1'b1;
                    else begin
                        err_cap <= M_AXI_ERROR;
                        state   <= done_edge ? REPORT : WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!M_AXI_TXN_DONE) armed <= 1'b1;
                    err_cap <= M_AXI_ERROR;
                    if (done_edge) state <= REPORT;
`ifdef MYIP_SCHED_TIMEOUT_EN
                    else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        err_cap <= 1'b1;
                        TIMEOUT <= 1'b1;
                        state   <= REPORT;
                    end else tcnt <= tcnt + 1'b1;
`endif
                end
                REPORT: begin
                    RUN_COUNT <= RUN_COUNT + 1'b1;
                    if (err_cap && !(&ERR_COUNT)) ERR_COUNT <= ERR_COUNT + 1'b1;
                    gap_cnt   <= '0;
                    state     <= (GAP_CYCLES == 0) ? IDLE : GAP;
                end
                GAP: if (gap_cnt == 8'(GAP_CYCLES - 1)) state <= IDLE;
                     else gap_cnt <= gap_cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_myip_txn_scheduler.sv
// tb_myip_txn_scheduler: directed checks of arbitration, engine handshake, counters and reset
module tb_myip_txn_scheduler;
    localparam int CW = 4;
    localparam int TO = 64;
    logic          ACLK = 1'b0, ARESETN = 1'b0;
    logic [1:0]    REQ_VALID = '0;
    logic [1:0]    REQ_GRANT, REQ_DONE, REQ_ERROR;
    logic          M_AXI_INIT_AXI_TXN, BUSY;
    logic          M_AXI_TXN_DONE = 1'b0, M_AXI_ERROR = 1'b0;
    logic [CW-1:0] RUN_COUNT, ERR_COUNT;
`ifdef MYIP_SCHED_TIMEOUT_EN
    logic          TIMEOUT;
`endif
    int checks = 0, fails = 0;

    always #5 ACLK = ~ACLK;

    myip_txn_scheduler #(
        .NUM_REQ(2), .INIT_PULSE_CYCLES(1), .GAP_CYCLES(2), .CNT_WIDTH(CW)
`ifdef MYIP_SCHED_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TO)
`endif
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .REQ_VALID(REQ_VALID), .REQ_GRANT(REQ_GRANT),
        .REQ_DONE(REQ_DONE), .REQ_ERROR(REQ_ERROR), .M_AXI_INIT_AXI_TXN(M_AXI_INIT_AXI_TXN),
        .M_AXI_TXN_DONE(M_AXI_TXN_DONE), .M_AXI_ERROR(M_AXI_ERROR), .BUSY(BUSY),
        .RUN_COUNT(RUN_COUNT), .ERR_COUNT(ERR_COUNT)
`ifdef MYIP_SCHED_TIMEOUT_EN
        , .TIMEOUT(TIMEOUT)
`endif
    );

    always @(negedge ACLK) if (ARESETN) begin
        checks++;
        if (|REQ_GRANT && |REQ_DONE) begin fails++; $display("FAIL grant_done_overlap grant=%b done=%b required no overlap", REQ_GRANT, REQ_DONE); end
    end

    task automatic apply_reset();
        ARESETN = 1'b0; REQ_VALID = '0; M_AXI_TXN_DONE = 1'b0; M_AXI_ERROR = 1'b0;
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
    endtask

    // behaves as the burst engine for one run and reports what the scheduler did
    task automatic do_run(input logic [1:0] rv, input bit hold, input int delay, input logic err, input int stale,
                          output logic [1:0] g, output int w, output int lat, output int il, output int early,
                          output logic [1:0] d, output logic [1:0] e);
        REQ_VALID = rv; g = '0; w = 0; lat = 0; il = 0; early = 0; d = '0; e = '0;
        while (g == '0 && w < 30) begin @(negedge ACLK); w++; g = REQ_GRANT; end
        if (!hold) REQ_VALID = '0;
        while (!M_AXI_INIT_AXI_TXN && lat < 10) begin @(negedge ACLK); lat++; end
        while (M_AXI_INIT_AXI_TXN && il < 10) begin il++; @(negedge ACLK); end
        repeat (stale) begin if (|REQ_DONE) early++; @(negedge ACLK); end
        M_AXI_TXN_DONE = 1'b0;
        repeat (delay) begin @(negedge ACLK); if (|REQ_DONE) early++; end
        M_AXI_TXN_DONE = 1'b1; M_AXI_ERROR = err;
        for (int i = 0; i < 10 && d == '0; i++) begin @(negedge ACLK); d = REQ_DONE; e = REQ_ERROR; end
        M_AXI_ERROR = 1'b0;
        @(negedge ACLK);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge ACLK);
        checks++; if (BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", BUSY); end
        checks++; if (M_AXI_INIT_AXI_TXN !== 1'b0) begin fails++; $display("FAIL reset_init got %b exp 0", M_AXI_INIT_AXI_TXN); end
        checks++; if (REQ_GRANT !== 2'b00 || REQ_DONE !== 2'b00) begin fails++; $display("FAIL reset_pulses grant=%b done=%b exp 00", REQ_GRANT, REQ_DONE); end
        checks++; if (RUN_COUNT !== '0 || ERR_COUNT !== '0) begin fails++; $display("FAIL reset_counts run=%0d err=%0d exp 0", RUN_COUNT, ERR_COUNT); end
    endtask

    task automatic test_single_run();
        logic [1:0] g, d, e; int w, l, il, early;
        apply_reset();
        do_run(2'b01, 0, 40, 1'b0, 0, g, w, l, il, early, d, e);
        checks++; if (g !== 2'b01) begin fails++; $display("FAIL single_grant got %b exp 01", g); end
        checks++; if (w !== 1) begin fails++; $display("FAIL single_grant_latency got %0d exp 1", w); end
        checks++; if (l !== 1) begin fails++; $display("FAIL single_init_latency got %0d exp 1", l); end
        checks++; if (il !== 1) begin fails++; $display("FAIL single_init_len got %0d exp 1", il); end
        checks++; if (early !== 0) begin fails++; $display("FAIL single_early_done got %0d exp 0", early); end
        checks++; if (d !== 2'b01 || e !== 2'b00) begin fails++; $display("FAIL single_done done=%b err=%b exp 01/00", d, e); end
        checks++; if (RUN_COUNT !== 4'd1 || ERR_COUNT !== 4'd0) begin fails++; $display("FAIL single_counts run=%0d err=%0d exp 1/0", RUN_COUNT, ERR_COUNT); end
    endtask

    task automatic test_round_robin();
        logic [1:0] g, d, e; int w, l, il, early;
        logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            do_run(2'b11, 1, 5, 1'b0, 0, g, w, l, il, early, d, e);
            checks++; if (g !== exp_g[i] || d !== exp_g[i]) begin fails++; $display("FAIL rr_run%0d grant=%b done=%b exp %b", i, g, d, exp_g[i]); end
            if (i > 0) begin
                checks++; if (w !== 3) begin fails++; $display("FAIL rr_gap%0d got %0d exp 3", i, w); end
            end
        end
        REQ_VALID = '0;
        checks++; if (RUN_COUNT !== 4'd4) begin fails++; $display("FAIL rr_count got %0d exp 4", RUN_COUNT); end
    endtask

    task automatic test_stale_done();
        logic [1:0] g, d, e; int w, l, il, early;
        apply_reset();
        do_run(2'b01, 0, 5, 1'b0, 0, g, w, l, il, early, d, e);
        checks++; if (d !== 2'b01) begin fails++; $display("FAIL stale_first_done got %b exp 01", d); end
        do_run(2'b10, 0, 4, 1'b0, 3, g, w, l, il, early, d, e);
        checks++; if (early !== 0) begin fails++; $display("FAIL stale_early_done got %0d exp 0", early); end
        checks++; if (g !== 2'b10 || d !== 2'b10) begin fails++; $display("FAIL stale_done grant=%b done=%b exp 10", g, d); end
    endtask

    task automatic test_error();
        logic [1:0] g, d, e; int w, l, il, early;
        apply_reset();
        do_run(2'b10, 0, 3, 1'b1, 0, g, w, l, il, early, d, e);
        checks++; if (d !== 2'b10 || e !== 2'b10) begin fails++; $display("FAIL err_flags done=%b err=%b exp 10/10", d, e); end
        checks++; if (ERR_COUNT !== 4'd1) begin fails++; $display("FAIL err_count1 got %0d exp 1", ERR_COUNT); end
        repeat (14) do_run(2'b01, 0, 2, 1'b1, 0, g, w, l, il, early, d, e);
        checks++; if (ERR_COUNT !== 4'd15 || RUN_COUNT !== 4'd15) begin fails++; $display("FAIL err_full err=%0d run=%0d exp 15/15", ERR_COUNT, RUN_COUNT); end
        do_run(2'b01, 0, 2, 1'b1, 0, g, w, l, il, early, d, e);
        checks++; if (ERR_COUNT !== 4'd15) begin fails++; $display("FAIL err_saturate got %0d exp 15", ERR_COUNT); end
        checks++; if (RUN_COUNT !== 4'd0) begin fails++; $display("FAIL run_wrap got %0d exp 0", RUN_COUNT); end
        do_run(2'b01, 0, 2, 1'b0, 0, g, w, l, il, early, d, e);
        checks++; if (e !== 2'b00 || ERR_COUNT !== 4'd15 || RUN_COUNT !== 4'd1) begin fails++; $display("FAIL err_clean err=%b errcnt=%0d run=%0d exp 00/15/1", e, ERR_COUNT, RUN_COUNT); end
    endtask

    task automatic test_reset_mid_run();
        logic [1:0] g, d, e; int w, l, il, early, n;
        apply_reset();
        do_run(2'b01, 0, 3, 1'b0, 0, g, w, l, il, early, d, e);
        repeat (4) @(negedge ACLK);
        REQ_VALID = 2'b10; n = 0;
        while (REQ_GRANT == '0 && n < 20) begin @(negedge ACLK); n++; end
        REQ_VALID = '0;
        @(negedge ACLK);
        checks++; if (M_AXI_INIT_AXI_TXN !== 1'b1) begin fails++; $display("FAIL mid_init_before got %b exp 1", M_AXI_INIT_AXI_TXN); end
        #2 ARESETN = 1'b0;
        #1;
        checks++; if (M_AXI_INIT_AXI_TXN !== 1'b0 || BUSY !== 1'b0) begin fails++; $display("FAIL mid_async init=%b busy=%b exp 0/0", M_AXI_INIT_AXI_TXN, BUSY); end
        checks++; if (RUN_COUNT !== '0 || ERR_COUNT !== '0) begin fails++; $display("FAIL mid_counts run=%0d err=%0d exp 0", RUN_COUNT, ERR_COUNT); end
        M_AXI_TXN_DONE = 1'b1;
        @(negedge ACLK); ARESETN = 1'b1;
        early = 0;
        repeat (5) begin @(negedge ACLK); if (|REQ_DONE) early++; end
        checks++; if (early !== 0) begin fails++; $display("FAIL mid_abandoned got %0d done pulses exp 0", early); end
        REQ_VALID = 2'b11; n = 0;
        while (REQ_GRANT == '0 && n < 20) begin @(negedge ACLK); n++; end
        checks++; if (REQ_GRANT !== 2'b01) begin fails++; $display("FAIL mid_first_grant got %b exp 01", REQ_GRANT); end
        REQ_VALID = '0;
    endtask

`ifdef MYIP_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        apply_reset();
        REQ_VALID = 2'b01; n = 0;
        while (REQ_GRANT == '0 && n < 20) begin @(negedge ACLK); n++; end
        REQ_VALID = '0; n = 0;
        while (!M_AXI_INIT_AXI_TXN && n < 10) begin @(negedge ACLK); n++; end
        while (M_AXI_INIT_AXI_TXN && n < 20) begin @(negedge ACLK); n++; end
        n = 0;
        while (REQ_DONE == '0 && n < 3 * TO) begin @(negedge ACLK); n++; end
        checks++; if (n !== TO) begin fails++; $display("FAIL to_latency got %0d exp %0d", n, TO); end
        checks++; if (REQ_ERROR !== 2'b01 || TIMEOUT !== 1'b1) begin fails++; $display("FAIL to_flags err=%b timeout=%b exp 01/1", REQ_ERROR, TIMEOUT); end
        repeat (6) @(negedge ACLK);
        checks++; if (TIMEOUT !== 1'b1 || ERR_COUNT !== 4'd1) begin fails++; $display("FAIL to_sticky timeout=%b err=%0d exp 1/1", TIMEOUT, ERR_COUNT); end
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_run();
        test_round_robin();
        test_stale_done();
        test_error();
        test_reset_mid_run();
`ifdef MYIP_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
